address_read: RTL and testbench
===============================

# address_read

Buffer-ID allocator for the centralized packet buffer. It pops free 9-bit buffer IDs from the free-bufid FIFO and hands one to each requesting receive port (p0..p8), using round-robin arbitration. It is the consumer side of the free list. Released IDs are written back into the same FIFO by the release stage.

## Interface
Parameters:
- LOW_WM, 16: free-ID low-watermark; o_bufid_low asserts while FIFO occupancy < LOW_WM.

Ports:
- clk_sys  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- iv_bufid_req  in  9  per-port request, bit N = port pN; level, held until ack
- ov_bufid_ack  out  9  one-hot, one-cycle ack to the granted port
- ov_bufid  out  9  allocated buffer ID, valid in the ack cycle, held until next ack
- o_bufid_fifo_rd  out  1  free-bufid FIFO read strobe (normal mode, data 1 cycle after strobe)
- iv_bufid_fifo_rdata  in  9  FIFO read data
- i_bufid_fifo_empty  in  1  FIFO empty
- iv_bufid_fifo_usedw  in  9  FIFO occupancy
- o_bufid_low  out  1  registered: empty or usedw < LOW_WM
- ov_alloc_cnt  out  16  total successful allocations, wraps 0xFFFF→0
- ov_address_read_state  out  2  FSM state, debug

## Operation
- FSM states:
  - idle_s=0: arbitration.
  - rd_s=1: FIFO strobe asserted.
  - cap_s=2: capture read data.
  - ack_s=3: ack visible.
- Arbitration is in idle_s.
  - A grant happens only if iv_bufid_req != 0 and i_bufid_fifo_empty == 0.
  - Round-robin pointer rr_ptr (0..8) sets the search order: rr_ptr, rr_ptr+1, …, wrapping 8→0.
  - The first set bit wins. Its index is registered in grant_port and the FSM goes to rd_s.
  - If there is no request, or the FIFO is empty, the FSM stays in idle_s. No strobe is issued.
- rd_s: o_bufid_fifo_rd=1 for exactly this cycle → cap_s.
- cap_s: o_bufid_fifo_rd=0.
  - ov_bufid ← iv_bufid_fifo_rdata.
  - ov_bufid_ack ← one-hot(grant_port).
  - rr_ptr ← grant_port+1, with 8 wrapping to 0.
  - ov_alloc_cnt ← +1.
  - → ack_s.
- ack_s: ov_bufid_ack ← 0 → idle_s.
  - This cycle is a guard so the acked port's request can fall before the next arbitration.
- Requester rule: req must be low no later than the cycle after ack. Otherwise it is treated as a new request.
- o_bufid_low is updated every cycle, independent of the FSM.
- An unknown state value → idle_s, with all strobes and acks cleared.
- Reset values:
  - ov_bufid_ack=0, ov_bufid=0, o_bufid_fifo_rd=0.
  - o_bufid_low=1, ov_alloc_cnt=0, ov_address_read_state=idle_s.
  - rr_ptr=0, grant_port=0.
- Reset mid-operation: an ID popped but not yet acked is discarded. The release side re-initialises the free list after reset.

## Timing
- Request seen in idle_s at cycle T:
  - strobe at T+1;
  - data captured at T+2;
  - ov_bufid and ack visible at T+3;
  - idle_s again at T+4.
- Latency from request to ack is 3 cycles. Sustained throughput is 1 allocation per 4 cycles.
- Exactly one FIFO read per ack. No read is issued while empty is sampled high in idle_s.
- FIFO empty rising after the strobe is ignored: the popped data is still delivered.
- Requests that arrive while the FSM is in rd_s, cap_s or ack_s wait until the next idle_s.
- Simultaneous requests are served in round-robin order, one per 4-cycle slot.
- o_bufid_low tracks the FIFO with 1-cycle latency.

## Test plan
- Reset, FIFO empty, iv_bufid_req=9'h001 held:
  - no o_bufid_fifo_rd, no ack;
  - o_bufid_low=1, state=0.
- FIFO holds 9,10,11; p3 requests at cycle T:
  - rd at T+1;
  - ov_bufid_ack=9'h008 and ov_bufid=9 at T+3 for one cycle;
  - ov_alloc_cnt=1;
  - next arbitration at T+4.
- All 9 ports request and stay held (dropping after ack), FIFO holds 20..28:
  - grants p0..p8 in order, receiving IDs 20..28;
  - acks spaced 4 cycles apart;
  - rr_ptr ends at 0.
- rr_ptr=8 (after a p7 grant), requests p2 and p8 together:
  - p8 is granted first, then p2;
  - ov_bufid follows FIFO order.
- FIFO usedw steps 17→16→15 with LOW_WM=16:
  - o_bufid_low goes 0→0→1, each one cycle after usedw changes.
- reset_n pulsed low in cap_s:
  - all outputs return to reset values immediately;
  - no ack pulse;
  - ov_alloc_cnt=0.

Source files
------------

// File: rtl/address_read_if.sv
// Request/ack and free-bufid FIFO bundle for the buffer-ID allocator.
// The allocator owns the slave modport; requesters and the FIFO own the master.
interface address_read_if;
    logic [8:0]  iv_bufid_req;
    logic [8:0]  ov_bufid_ack;
    logic [8:0]  ov_bufid;
    logic        o_bufid_fifo_rd;
    logic [8:0]  iv_bufid_fifo_rdata;
    logic        i_bufid_fifo_empty;
    logic [8:0]  iv_bufid_fifo_usedw;
    logic        o_bufid_low;
    logic [15:0] ov_alloc_cnt;
    logic [1:0]  ov_address_read_state;

    modport slave (
        input  iv_bufid_req, iv_bufid_fifo_rdata, i_bufid_fifo_empty, iv_bufid_fifo_usedw,
        output ov_bufid_ack, ov_bufid, o_bufid_fifo_rd, o_bufid_low, ov_alloc_cnt,
        output ov_address_read_state
    );

    modport master (
        output iv_bufid_req, iv_bufid_fifo_rdata, i_bufid_fifo_empty, iv_bufid_fifo_usedw,
        input  ov_bufid_ack, ov_bufid, o_bufid_fifo_rd, o_bufid_low, ov_alloc_cnt,
        input  ov_address_read_state
    );
endinterface

// File: rtl/address_read.sv
// Buffer-ID allocator: pops free IDs from the free-bufid FIFO and grants them
// round-robin to ports p0..p8, one allocation per 4-cycle slot.
module address_read #(
    parameter int LOW_WM = 16
) (
    input  logic         clk_sys,
    input  logic         reset_n,
    address_read_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        RD_S   = 2'd1,
        CAP_S  = 2'd2,
        ACK_S  = 2'd3
    } state_t;

    state_t      state, state_nxt;
    logic [3:0]  rr_ptr, rr_nxt;
    logic [3:0]  grant_port, grant_nxt;
    logic [8:0]  ack, ack_nxt;
    logic [8:0]  bufid, bufid_nxt;
    logic        fifo_rd, fifo_rd_nxt;
    logic [15:0] alloc_cnt, alloc_cnt_nxt;
    logic        bufid_low;

    logic [3:0]  sel;
    logic        found;
    logic [4:0]  idx;

    // Search order starts at rr_ptr and wraps 8 -> 0; first requester wins.
    always_comb begin
        sel   = 4'd0;
        found = 1'b0;
        idx   = 5'd0;
        for (int k = 0; k < 9; k++) begin
            idx = {1'b0, rr_ptr} + 5'(k);
            if (idx >= 5'd9) idx = idx - 5'd9;
            if (!found && bus.iv_bufid_req[idx[3:0]]) begin
                found = 1'b1;
                sel   = idx[3:0];
            end
        end
    end

    always_comb begin
        state_nxt     = state;
        rr_nxt        = rr_ptr;
        grant_nxt     = grant_port;
        ack_nxt       = ack;
        bufid_nxt     = bufid;
        fifo_rd_nxt   = 1'b0;
        alloc_cnt_nxt = alloc_cnt;
        case (state)
            IDLE_S: begin
                if (found && !bus.i_bufid_fifo_empty) begin
                    grant_nxt   = sel;
                    fifo_rd_nxt = 1'b1;
                    state_nxt   = RD_S;
                end
            end
            RD_S: state_nxt = CAP_S;
            CAP_S: begin
                // FIFO data is valid one cycle after the strobe; empty is ignored here.
                bufid_nxt     = bus.iv_bufid_fifo_rdata;
                ack_nxt       = 9'b1 << grant_port;
                rr_nxt        = (grant_port == 4'd8) ? 4'd0 : grant_port + 4'd1;
                alloc_cnt_nxt = alloc_cnt + 16'd1;
                state_nxt     = ACK_S;
            end
            ACK_S: begin
                // Guard cycle: lets the acked port drop its request before re-arbitration.
                ack_nxt   = 9'd0;
                state_nxt = IDLE_S;
            end
            default: begin
                ack_nxt     = 9'd0;
                fifo_rd_nxt = 1'b0;
                state_nxt   = IDLE_S;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE_S;
            rr_ptr     <= 4'd0;
            grant_port <= 4'd0;
            ack        <= 9'd0;
            bufid      <= 9'd0;
            fifo_rd    <= 1'b0;
            alloc_cnt  <= 16'd0;
        end else begin
            state      <= state_nxt;
            rr_ptr     <= rr_nxt;
            grant_port <= grant_nxt;
            ack        <= ack_nxt;
            bufid      <= bufid_nxt;
            fifo_rd    <= fifo_rd_nxt;
            alloc_cnt  <= alloc_cnt_nxt;
        end
    end

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) bufid_low <= 1'b1;
        else          bufid_low <= bus.i_bufid_fifo_empty ||
                                   (32'(bus.iv_bufid_fifo_usedw) < LOW_WM);
    end

    assign bus.ov_bufid_ack          = ack;
    assign bus.ov_bufid              = bufid;
    assign bus.o_bufid_fifo_rd       = fifo_rd;
    assign bus.o_bufid_low           = bufid_low;
    assign bus.ov_alloc_cnt          = alloc_cnt;
    assign bus.ov_address_read_state = state;
endmodule

// File: tb/tb_address_read.sv
// Directed plus randomized checks of address_read against a FIFO model and a
// round-robin reference computed from the grant rules.
module tb_address_read;
    logic clk_sys = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_sys = ~clk_sys;

    address_read_if bus ();
    address_read #(.LOW_WM(16)) dut (.clk_sys(clk_sys), .reset_n(reset_n), .bus(bus));

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Free-bufid FIFO model: normal-mode read, data one cycle after strobe.
    int         q[$];
    logic       ovr = 1'b0;
    logic [8:0] ovr_usedw = 9'd0;
    initial begin
        bus.iv_bufid_fifo_rdata = 9'd0;
        bus.i_bufid_fifo_empty  = 1'b1;
        bus.iv_bufid_fifo_usedw = 9'd0;
    end
    always @(posedge clk_sys) begin
        cyc <= cyc + 1;
        if (bus.o_bufid_fifo_rd && q.size() != 0) bus.iv_bufid_fifo_rdata <= 9'(q.pop_front());
        bus.i_bufid_fifo_empty  <= ovr ? 1'b0 : (q.size() == 0);
        bus.iv_bufid_fifo_usedw <= ovr ? ovr_usedw : 9'(q.size());
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        @(negedge clk_sys);
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (bus.ov_bufid_ack == 9'd0 && n < 10) begin
            tick();
            n++;
        end
        chk({tag, "_timeout"}, 32'(bus.ov_bufid_ack != 9'd0), 32'd1);
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();
    endtask

    int         ref_ids[$];
    logic [8:0] pend;
    int         rr, p, exp_cnt, last_rd, last_ack, wait_cyc, n_rd, n_ack, id;
    bit         fnd;

    initial begin
        bus.iv_bufid_req = 9'h001;
        // Reset with FIFO empty and a request held: nothing may happen.
        tick();
        chk("rst_ack", 32'(bus.ov_bufid_ack), 32'd0);
        chk("rst_bufid", 32'(bus.ov_bufid), 32'd0);
        chk("rst_cnt", 32'(bus.ov_alloc_cnt), 32'd0);
        chk("rst_low", 32'(bus.o_bufid_low), 32'd1);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("empty_rd", 32'(bus.o_bufid_fifo_rd), 32'd0);
            chk("empty_ack", 32'(bus.ov_bufid_ack), 32'd0);
            chk("empty_low", 32'(bus.o_bufid_low), 32'd1);
            chk("empty_state", 32'(bus.ov_address_read_state), 32'd0);
        end

        // Single request from p3, FIFO holds 9,10,11.
        bus.iv_bufid_req = 9'd0;
        q = '{9, 10, 11};
        tick();
        bus.iv_bufid_req = 9'h008;
        tick();
        chk("p3_rd", 32'(bus.o_bufid_fifo_rd), 32'd1);
        chk("p3_st_rd", 32'(bus.ov_address_read_state), 32'd1);
        tick();
        chk("p3_rd_off", 32'(bus.o_bufid_fifo_rd), 32'd0);
        chk("p3_early_ack", 32'(bus.ov_bufid_ack), 32'd0);
        tick();
        chk("p3_ack", 32'(bus.ov_bufid_ack), 32'h008);
        chk("p3_bufid", 32'(bus.ov_bufid), 32'd9);
        chk("p3_cnt", 32'(bus.ov_alloc_cnt), 32'd1);
        bus.iv_bufid_req = 9'd0;
        tick();
        chk("p3_ack_off", 32'(bus.ov_bufid_ack), 32'd0);
        chk("p3_idle", 32'(bus.ov_address_read_state), 32'd0);
        chk("p3_hold", 32'(bus.ov_bufid), 32'd9);

        // All nine ports requesting from rr_ptr=0, IDs 20..28.
        do_reset();
        q = {};
        for (int i = 0; i < 9; i++) q.push_back(20 + i);
        tick();
        bus.iv_bufid_req = 9'h1FF;
        for (int i = 0; i < 9; i++) begin
            wait_ack("all9");
            chk("all9_port", 32'(bus.ov_bufid_ack), 32'(1) << i);
            chk("all9_id", 32'(bus.ov_bufid), 32'(20 + i));
            if (i > 0) chk("all9_gap", 32'(cyc - last_ack), 32'd4);
            last_ack = cyc;
            bus.iv_bufid_req[i] = 1'b0;
            tick();
        end
        // rr_ptr wrapped to 0: p0 beats p8.
        q.push_back(30);
        tick();
        bus.iv_bufid_req = 9'h101;
        wait_ack("wrap");
        chk("wrap_port", 32'(bus.ov_bufid_ack), 32'h001);
        chk("wrap_id", 32'(bus.ov_bufid), 32'd30);
        bus.iv_bufid_req = 9'd0;
        tick();

        // rr_ptr=8 after a p7 grant; p2 and p8 together -> p8 then p2.
        q = '{40, 41, 42};
        tick();
        bus.iv_bufid_req = 9'h080;
        wait_ack("p7");
        chk("p7_port", 32'(bus.ov_bufid_ack), 32'h080);
        bus.iv_bufid_req = 9'h104;
        tick();
        wait_ack("p8");
        chk("p8_port", 32'(bus.ov_bufid_ack), 32'h100);
        chk("p8_id", 32'(bus.ov_bufid), 32'd41);
        bus.iv_bufid_req = 9'h004;
        tick();
        wait_ack("p2");
        chk("p2_port", 32'(bus.ov_bufid_ack), 32'h004);
        chk("p2_id", 32'(bus.ov_bufid), 32'd42);
        bus.iv_bufid_req = 9'd0;
        tick();

        // Low watermark: usedw 17 -> 16 -> 15, low follows one cycle later.
        ovr = 1'b1;
        ovr_usedw = 9'd17;
        tick();
        tick();
        chk("wm_17", 32'(bus.o_bufid_low), 32'd0);
        ovr_usedw = 9'd16;
        tick();
        chk("wm_16a", 32'(bus.o_bufid_low), 32'd0);
        tick();
        chk("wm_16b", 32'(bus.o_bufid_low), 32'd0);
        ovr_usedw = 9'd15;
        tick();
        chk("wm_15_lag", 32'(bus.o_bufid_low), 32'd0);
        tick();
        chk("wm_15", 32'(bus.o_bufid_low), 32'd1);
        ovr = 1'b0;
        tick();

        // Reset pulse while in cap_s discards the popped ID.
        q = '{50};
        tick();
        bus.iv_bufid_req = 9'h002;
        tick();
        tick();
        chk("cap_state", 32'(bus.ov_address_read_state), 32'd2);
        reset_n = 1'b0;
        #1;
        chk("cap_rst_ack", 32'(bus.ov_bufid_ack), 32'd0);
        chk("cap_rst_state", 32'(bus.ov_address_read_state), 32'd0);
        chk("cap_rst_cnt", 32'(bus.ov_alloc_cnt), 32'd0);
        chk("cap_rst_bufid", 32'(bus.ov_bufid), 32'd0);
        chk("cap_rst_rd", 32'(bus.o_bufid_fifo_rd), 32'd0);
        chk("cap_rst_low", 32'(bus.o_bufid_low), 32'd1);
        bus.iv_bufid_req = 9'd0;
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("cap_no_ack", 32'(bus.ov_bufid_ack), 32'd0);
        end

        // Randomized traffic against the round-robin reference.
        do_reset();
        q = {};
        ref_ids = {};
        for (int i = 0; i < 40; i++) begin
            id = 32'($urandom_range(0, 511));
            q.push_back(id);
            ref_ids.push_back(id);
        end
        tick();
        pend = 9'd0; rr = 0; exp_cnt = 0; last_rd = -10;
        wait_cyc = 0; n_rd = 0; n_ack = 0;
        for (int c = 0; c < 320; c++) begin
            if (bus.o_bufid_fifo_rd) begin
                chk("rnd_rd_nonempty", 32'(ref_ids.size() != 0), 32'd1);
                last_rd = c;
                n_rd++;
            end
            if (bus.ov_bufid_ack != 9'd0) begin
                fnd = 1'b0; p = 0;
                for (int k = 0; k < 9; k++)
                    if (!fnd && pend[(rr + k) % 9]) begin fnd = 1'b1; p = (rr + k) % 9; end
                chk("rnd_port", 32'(bus.ov_bufid_ack), fnd ? (32'(1) << p) : 32'd0);
                chk("rnd_id", 32'(bus.ov_bufid), ref_ids.size() != 0 ? 32'(ref_ids.pop_front()) : 32'hFFFF);
                exp_cnt++;
                n_ack++;
                chk("rnd_cnt", 32'(bus.ov_alloc_cnt), 32'(exp_cnt));
                chk("rnd_latency", 32'(c - last_rd), 32'd2);
                rr = (p + 1) % 9;
                pend[p] = 1'b0;
                wait_cyc = 0;
                if ($urandom_range(0, 1) == 1) pend = pend | 9'($urandom_range(0, 511));
            end else if (pend == 9'd0) begin
                pend = 9'($urandom_range(0, 511));
            end else if (ref_ids.size() != 0) begin
                wait_cyc++;
                if (wait_cyc > 6) begin
                    chk("rnd_ack_timeout", 32'(wait_cyc), 32'd6);
                    break;
                end
            end
            bus.iv_bufid_req = pend;
            tick();
        end
        chk("rnd_all_alloc", 32'(n_ack), 32'd40);
        chk("rnd_rd_eq_ack", 32'(n_rd), 32'(n_ack));
        chk("rnd_final_cnt", 32'(bus.ov_alloc_cnt), 32'd40);
        chk("rnd_empty_low", 32'(bus.o_bufid_low), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
